// File: rtl/time_set_buttons.sv
// Button front end for the time-set path: per-button sync, debounce and
// auto-repeat, with hour-first arbitration onto the two increment strobes.
`timescale 1ns/1ps

// One button channel: 2-flop synchroniser, stability debouncer, repeat FSM.
// state   | meaning
// IDLE    | waiting for a debounced press while setMode is high
// DELAY   | press pulsed, timing the initial hold before auto-repeat
// REPEAT  | auto-repeating every REPEAT_PERIOD cycles
// LOCKOUT | button held across setMode low; wait for release
module time_set_buttons_chan #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REPEAT_DELAY    = 2500000,
    parameter int REPEAT_PERIOD   = 1000000
) (
    input  logic clk5MHz,
    input  logic resetN,
    input  logic btn,
    input  logic setMode,
    output logic req
);
    localparam int CW = 22;
    localparam logic [CW-1:0] DB_TC = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] RD_TC = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] RP_TC = CW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT, LOCKOUT} state_t;

    logic          sync1, sync2, level, level_d;
    logic          db_done, level_nxt;
    logic [CW-1:0] db_cnt, rep_cnt, rep_cnt_nxt;
    state_t        state, state_nxt;

    // the level only moves after DEBOUNCE_CYCLES of an unchanged, differing input
    assign db_done   = (sync2 != level) && (sync1 == sync2) && (db_cnt == DB_TC);
    assign level_nxt = db_done ? sync2 : level;

    always_ff @(posedge clk5MHz) begin
        if (!resetN) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            db_cnt  <= '0;
        end else begin
            sync1   <= btn;
            sync2   <= sync1;
            level   <= level_nxt;
            level_d <= level;
            if ((sync2 == level) || (sync1 != sync2) || db_done)
                db_cnt <= '0;
            else
                db_cnt <= db_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk5MHz) begin
        if (!resetN) begin
            state   <= IDLE;
            rep_cnt <= '0;
        end else begin
            state   <= state_nxt;
            rep_cnt <= rep_cnt_nxt;
        end
    end

    // release is judged on level_nxt so nothing is requested on the falling edge itself
    always_comb begin
        state_nxt   = state;
        rep_cnt_nxt = rep_cnt;
        req         = 1'b0;
        if (!setMode) begin
            state_nxt   = level ? LOCKOUT : IDLE;
            rep_cnt_nxt = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (level && !level_d) begin
                        req         = 1'b1;
                        rep_cnt_nxt = '0;
                        state_nxt   = DELAY;
                    end
                end
                DELAY: begin
                    if (!level_nxt) begin
                        rep_cnt_nxt = '0;
                        state_nxt   = IDLE;
                    end else if (rep_cnt == RD_TC) begin
                        req         = 1'b1;
                        rep_cnt_nxt = '0;
                        state_nxt   = REPEAT;
                    end else begin
                        rep_cnt_nxt = rep_cnt + CW'(1);
                    end
                end
                REPEAT: begin
                    if (!level_nxt) begin
                        rep_cnt_nxt = '0;
                        state_nxt   = IDLE;
                    end else if (rep_cnt == RP_TC) begin
                        req         = 1'b1;
                        rep_cnt_nxt = '0;
                    end else begin
                        rep_cnt_nxt = rep_cnt + CW'(1);
                    end
                end
                LOCKOUT: begin
                    if (!level)
                        state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end
endmodule

module time_set_buttons #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REPEAT_DELAY    = 2500000,
    parameter int REPEAT_PERIOD   = 1000000
) (
    input  logic clk5MHz,
    input  logic resetN,
    input  logic btnMin,
    input  logic btnHour,
    input  logic setMode,
    output logic inc1min,
    output logic inc1hour
);
    logic req_min, req_hour, pend_min;

    time_set_buttons_chan #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_min (
        .clk5MHz(clk5MHz),
        .resetN (resetN),
        .btn    (btnMin),
        .setMode(setMode),
        .req    (req_min)
    );

    time_set_buttons_chan #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_hour (
        .clk5MHz(clk5MHz),
        .resetN (resetN),
        .btn    (btnHour),
        .setMode(setMode),
        .req    (req_hour)
    );

    // hour wins a collision; the minute request waits one slot in pend_min
    always_ff @(posedge clk5MHz) begin
        if (!resetN || !setMode) begin
            inc1min  <= 1'b0;
            inc1hour <= 1'b0;
            pend_min <= 1'b0;
        end else begin
            inc1hour <= req_hour;
            if (req_hour) begin
                inc1min  <= 1'b0;
                pend_min <= pend_min | req_min;
            end else begin
                inc1min  <= req_min | pend_min;
                pend_min <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_time_set_buttons.sv
// Scoreboard bench: planned input waveforms, expected strobe edges derived from
// press/release arithmetic, checked by an independent negedge monitor.
`timescale 1ns/1ps

module tb_time_set_buttons;
    localparam int D  = 4;
    localparam int RD = 20;
    localparam int RP = 8;

    logic clk5MHz = 1'b0;
    logic resetN  = 1'b0;
    logic btnMin  = 1'b0;
    logic btnHour = 1'b0;
    logic setMode = 1'b0;
    logic inc1min, inc1hour;

    time_set_buttons #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk5MHz (clk5MHz),
        .resetN  (resetN),
        .btnMin  (btnMin),
        .btnHour (btnHour),
        .setMode (setMode),
        .inc1min (inc1min),
        .inc1hour(inc1hour)
    );

    always #100 clk5MHz = ~clk5MHz;

    int cyc = 0;
    always @(posedge clk5MHz) cyc <= cyc + 1;

    typedef struct {int at; bit hour;} ev_t;
    ev_t sb[$];
    ev_t tmp[$];

    int  n_chk  = 0;
    int  n_fail = 0;
    bit  mon_en = 1'b0;

    // plan: element i is sampled by the DUT at edge base+i
    bit w_min[$], w_hour[$], w_mode[$], w_rst[$];
    bit rq[$];
    int req_m[$], req_h[$];

    task automatic clr_plan();
        w_min.delete(); w_hour.delete(); w_mode.delete(); w_rst.delete();
    endtask

    task automatic seg(input bit mn, input bit hr, input bit md, input bit rs, input int n);
        for (int i = 0; i < n; i++) begin
            w_min.push_back(mn); w_hour.push_back(hr);
            w_mode.push_back(md); w_rst.push_back(rs);
        end
    endtask

    function automatic bit eff(input int ch, input int i);
        return !w_rst[i] && (ch != 0 ? w_hour[i] : w_min[i]);
    endfunction

    // a press sampled from k to f-1 pulses at k+3+D, then +RD, then every +RP,
    // until the debounced release (f+2+D) or a reset; setMode must stay high throughout
    task automatic chan_model(input int ch);
        int n, i, k, f, lim, e, step;
        bit ok, cut;
        n = w_min.size();
        i = 0;
        if (ch != 0) req_h.delete(); else req_m.delete();
        while (i < n) begin
            if (!eff(ch, i)) begin
                i++;
            end else begin
                k = i;
                while (i < n && eff(ch, i)) i++;
                f   = i;
                cut = (f < n) && w_rst[f];
                lim = f + 2 + D;
                for (int t = f; t < f + 2 + D && t < n; t++)
                    if (w_rst[t]) begin lim = t; break; end
                if (cut || (f - k >= D + 2)) begin
                    e = k + 3 + D; step = RD; ok = 1'b1;
                    while (ok && e < lim && e < n) begin
                        for (int j = k + 3 + D; j <= e; j++)
                            if (!w_mode[j]) ok = 1'b0;
                        if (ok) begin
                            if (ch != 0) req_h.push_back(e); else req_m.push_back(e);
                            e = e + step;
                            step = RP;
                        end
                    end
                end
            end
        end
    endtask

    task automatic build_expect(input int base);
        int n;
        bit hit;
        ev_t ev, sw;
        n = w_min.size();
        chan_model(0);
        chan_model(1);
        tmp.delete();
        foreach (req_h[i]) begin
            ev.at = base + req_h[i]; ev.hour = 1'b1; tmp.push_back(ev);
        end
        foreach (req_m[i]) begin
            hit = 1'b0;
            foreach (req_h[j]) if (req_h[j] == req_m[i]) hit = 1'b1;
            ev.hour = 1'b0;
            if (!hit) begin
                ev.at = base + req_m[i]; tmp.push_back(ev);
            end else if (req_m[i] + 1 < n && w_mode[req_m[i] + 1] && !w_rst[req_m[i] + 1]) begin
                ev.at = base + req_m[i] + 1; tmp.push_back(ev);
            end
        end
        for (int i = 1; i < tmp.size(); i++)
            for (int j = i; j > 0 && tmp[j-1].at > tmp[j].at; j--) begin
                sw = tmp[j]; tmp[j] = tmp[j-1]; tmp[j-1] = sw;
            end
        foreach (tmp[i]) sb.push_back(tmp[i]);
    endtask

    task automatic run_plan();
        int base;
        base = cyc + 1;
        build_expect(base);
        for (int i = 0; i < w_min.size(); i++) begin
            btnMin = w_min[i]; btnHour = w_hour[i];
            setMode = w_mode[i]; resetN = !w_rst[i];
            @(posedge clk5MHz); #1;
            if (w_rst[i]) begin
                n_chk++;
                if (inc1min || inc1hour) begin
                    n_fail++;
                    $display("FAIL reset_out: edge %0d inc1min=%0b inc1hour=%0b, required 0/0", cyc, inc1min, inc1hour);
                end
            end
        end
    endtask

    task automatic rand_btn(input int n);
        rq.delete();
        while (rq.size() < n) begin
            repeat ($urandom_range(D + 2, 20)) rq.push_back(1'b0);
            if ($urandom_range(0, 3) == 0)
                repeat ($urandom_range(1, D - 1)) rq.push_back(1'b1);
            else
                repeat ($urandom_range(D + 2, 50)) rq.push_back(1'b1);
        end
        repeat (D + 2) rq.push_back(1'b0);
    endtask

    task automatic rand_plan(input int n);
        int len;
        clr_plan();
        rand_btn(n); w_min = rq;
        rand_btn(n); w_hour = rq;
        len = (w_min.size() > w_hour.size()) ? w_min.size() : w_hour.size();
        while (w_min.size() < len)  w_min.push_back(1'b0);
        while (w_hour.size() < len) w_hour.push_back(1'b0);
        while (w_mode.size() < len) begin
            repeat ($urandom_range(20, 80)) w_mode.push_back(1'b1);
            repeat ($urandom_range(1, 10))  w_mode.push_back(1'b0);
        end
        while (w_mode.size() > len) void'(w_mode.pop_back());
        repeat (len) w_rst.push_back(1'b0);
        seg(0, 0, 1, 0, 30);
    endtask

    task automatic check_pulse(input bit hr);
        n_chk++;
        if (sb.size() > 0 && sb[0].at == cyc && sb[0].hour == hr) begin
            void'(sb.pop_front());
        end else begin
            n_fail++;
            if (sb.size() > 0)
                $display("FAIL unexpected_pulse: hour=%0b at edge %0d, required next hour=%0b at edge %0d",
                         hr, cyc, sb[0].hour, sb[0].at);
            else
                $display("FAIL unexpected_pulse: hour=%0b at edge %0d, required none", hr, cyc);
        end
    endtask

    always @(negedge clk5MHz) begin
        if (mon_en) begin
            while (sb.size() > 0 && sb[0].at < cyc) begin
                n_chk++; n_fail++;
                $display("FAIL missed_pulse: hour=%0b required at edge %0d, no pulse by edge %0d",
                         sb[0].hour, sb[0].at, cyc);
                void'(sb.pop_front());
            end
            if (inc1min && inc1hour) begin
                n_chk++; n_fail++;
                $display("FAIL both_high: edge %0d inc1min=1 inc1hour=1, required not both", cyc);
            end
            if (inc1hour) check_pulse(1'b1);
            if (inc1min)  check_pulse(1'b0);
        end
    end

    initial begin
        repeat (3) @(posedge clk5MHz);
        #1;
        mon_en = 1'b1;

        // reset held with both buttons high, then minute held alone
        clr_plan();
        seg(1, 1, 1, 1, 3);
        seg(1, 0, 1, 0, 12);
        seg(0, 0, 1, 0, 30);
        run_plan();

        // single press with auto-repeat
        clr_plan();
        seg(1, 0, 1, 0, 60);
        seg(0, 0, 1, 0, 40);
        run_plan();

        // bounce, then a clean 10-cycle press
        clr_plan();
        seg(0, 1, 1, 0, 2); seg(0, 0, 1, 0, 2);
        seg(0, 1, 1, 0, 2); seg(0, 0, 1, 0, 20);
        seg(0, 1, 1, 0, 10); seg(0, 0, 1, 0, 40);
        run_plan();

        // simultaneous press
        clr_plan();
        seg(1, 1, 1, 0, 28);
        seg(0, 0, 1, 0, 40);
        run_plan();

        // setMode gating and lockout
        clr_plan();
        seg(1, 0, 0, 0, 12); seg(1, 0, 1, 0, 10); seg(0, 0, 1, 0, 12);
        seg(1, 0, 1, 0, 40); seg(1, 0, 0, 0, 5);  seg(1, 0, 1, 0, 10);
        seg(0, 0, 1, 0, 30);
        run_plan();

        // reset during REPEAT with the button held throughout
        clr_plan();
        seg(0, 1, 1, 0, 40); seg(0, 1, 1, 1, 1);
        seg(0, 1, 1, 0, 35); seg(0, 0, 1, 0, 40);
        run_plan();

        for (int r = 0; r < 8; r++) begin
            rand_plan(150);
            run_plan();
        end

        repeat (5) @(posedge clk5MHz);
        #1;
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL leftover_expected: %0d pulses outstanding, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/time_set_buttons.md
# time_set_buttons

Pushbutton front end for the alarm clock's time-setting path. It synchronises and debounces the raw minute and hour buttons and produces the one-cycle `inc1min` / `inc1hour` strobes that the time counters consume and that `clockDivider` uses to restart its blink clock. While a button is held, it auto-repeats. All logic runs on the 5 MHz system clock.

## Interface

- `DEBOUNCE_CYCLES`, 50000: consecutive stable cycles before a debounced level changes (10 ms at 5 MHz).
- `REPEAT_DELAY`, 2500000: cycles from the initial press pulse to the first auto-repeat pulse (0.5 s).
- `REPEAT_PERIOD`, 1000000: cycles between subsequent auto-repeat pulses (0.2 s).

- `clk5MHz` input 1: system clock; all state updates on the rising edge.
- `resetN` input 1: synchronous, active-low reset.
- `btnMin` input 1: raw minute button, asynchronous, active-high.
- `btnHour` input 1: raw hour button, asynchronous, active-high.
- `setMode` input 1: time-set enable; pulses are generated only while it is high.
- `inc1min` output 1: one-cycle increment-minute strobe.
- `inc1hour` output 1: one-cycle increment-hour strobe.

## Operation

- Each button has an identical channel made of three stages.
  - **Synchroniser:** 2-flop synchroniser.
  - **Debouncer:** 22-bit stability counter and a debounced level. The counter clears whenever the synchronised value equals the debounced level or changes. When it reaches `DEBOUNCE_CYCLES`, the debounced level takes the synchronised value and the counter clears.
  - **Repeat FSM:** drives the channel's pulse request (below).
- Repeat FSM states, one 22-bit repeat counter per channel:
  - `IDLE`: on a debounced rising edge with `setMode`=1, request a pulse, clear the counter, go to `DELAY`.
  - `DELAY`: count up. On count == `REPEAT_DELAY`-1, request a pulse, clear the counter, go to `REPEAT`.
  - `REPEAT`: count up. On count == `REPEAT_PERIOD`-1, request a pulse and clear the counter.
  - `LOCKOUT`: no requests. Go to `IDLE` when the debounced level is 0.
  - From `DELAY` or `REPEAT`, debounced level 0 goes to `IDLE` with no pulse.
- `setMode` low, any cycle: every channel goes to `LOCKOUT` if its debounced level is 1, otherwise to `IDLE`. No requests are made. A button already held when `setMode` rises must be released and pressed again before it pulses.
- Arbitration: `inc1min` and `inc1hour` are never high in the same cycle.
  - If both channels request in the same cycle, the hour pulse is issued and the minute request is held in a 1-deep pending flag.
  - The pending flag is issued the next cycle, or the first following cycle with no hour request. Its timing basis is the channel's own counter, not the deferred issue cycle.
  - The pending flag clears on `setMode`=0 or on reset.
- Counter widths: 22 bits. Every parameter must be ≤ 4194303. The counters never wrap.

## Timing

- Reset (`resetN`=0 at a clock edge) clears the following:
  - `inc1min`=0, `inc1hour`=0.
  - Synchronisers and debounced levels = 0.
  - All counters = 0, FSMs in `IDLE`, pending flag = 0.
- Reset mid-repeat aborts with no further pulses. A button still held after reset is seen as a new press, once the debounce completes, if `setMode`=1.
- Outputs are registered.
- Press latency:
  - A raw rise first sampled at edge k raises the debounced level at edge k+2+`DEBOUNCE_CYCLES`.
  - The pulse is high for exactly the one cycle following edge k+3+`DEBOUNCE_CYCLES`.
- Repeat spacing on one output:
  - First repeat: `REPEAT_DELAY` cycles after the press pulse.
  - Then every `REPEAT_PERIOD` cycles.
- Release latency: the debounced fall arrives 2+`DEBOUNCE_CYCLES` cycles after the raw fall. No pulse is issued on or after that edge.
- Bounce: any raw glitch shorter than `DEBOUNCE_CYCLES` cycles produces no pulse and no change in the debounced level.

## Test plan

All scenarios use `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=20, `REPEAT_PERIOD`=8.

- **Reset state:** hold `resetN`=0 for 3 cycles with both buttons high -> both outputs 0 throughout. After release with `setMode`=1, one `inc1min` pulse appears 7 cycles later.
- **Single press and auto-repeat:** `setMode`=1, raise `btnMin` at cycle 0 and hold for 60 cycles.
  - `inc1min` is high at cycles 7, 27, 35, 43, 51, 59.
  - After release, no pulse follows cycle 59.
  - `inc1hour` stays 0.
- **Bounce rejection:** toggle `btnHour` 1-0-1-0 with 2-cycle widths, then leave it low -> no `inc1hour` pulse. Then hold it high for 10 cycles -> exactly one pulse, at 7 cycles after the final rise.
- **Simultaneous press:** raise both buttons in the same cycle with `setMode`=1 -> `inc1hour` pulses at cycle 7 and `inc1min` at cycle 8. At the repeats, hour is at 27 and minute at 28.
- **setMode gating:**
  - Hold `btnMin` with `setMode`=0, then raise `setMode` -> no pulse.
  - Release `btnMin`, then press again -> pulse 7 cycles after the press.
  - Drop `setMode` during `REPEAT` -> pulses stop immediately.
- **Reset mid-repeat:** assert `resetN`=0 for 1 cycle during `REPEAT` while the button is held -> no pulse during reset. With the button still held, the next pulse appears 7 cycles after reset release, followed by a repeat 20 cycles after that pulse.
